cv32e40p_tmr_monitor: RTL and testbench

Fault monitor for the triplicated execution datapath. It observes the three replica outputs ahead of the majority voter and classifies every valid comparison as clean, single-replica fault or uncorrectable. It keeps per-replica error statistics, flags replicas that are permanently faulty, and streams fault events to a consumer (debug unit / fault log) over a valid/ready handshake.

---
 rtl/cv32e40p_pkg.sv | 19 +
 rtl/cv32e40p_tmr_evt_fifo.sv | 77 +++++++
 rtl/cv32e40p_tmr_monitor.sv | 122 ++++++++++++
 tb/tb_cv32e40p_tmr_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_pkg : shared types and constants for the TMR fault monitor | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cv32e40p_pkg;

  typedef enum logic [1:0] {
    TMR_EVT_UNCORR = 2'd0,
    TMR_EVT_R1     = 2'd1,
    TMR_EVT_R2     = 2'd2,
    TMR_EVT_R3     = 2'd3
  } tmr_evt_e;

  localparam int unsigned TMR_EVT_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_tmr_evt_fifo.sv
// ---------------------------------------------------------------------------
// cv32e40p_tmr_evt_fifo : small event queue, pop-before-push when full | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40p_tmr_evt_fifo
  import cv32e40p_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic [1:0] push_id_i,
  input  logic       pop_i,
  output logic       valid_o,
  output logic       empty_o,
  output logic [1:0] id_o,
  output logic       ovf_o
);

  localparam int unsigned CW = $clog2(TMR_EVT_DEPTH + 1);
  localparam int unsigned IW = (TMR_EVT_DEPTH > 1) ? $clog2(TMR_EVT_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TMR_EVT_DEPTH);

  logic [TMR_EVT_DEPTH-1:0][1:0] mem_q, mem_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          valid_q, ovf_q, ovf_d;
  logic                          pop, full;

  assign full    = (cnt_q == DEPTH_C);
  assign pop     = pop_i & (cnt_q != '0);
  assign valid_o = valid_q;
  assign empty_o = (cnt_q == '0);
  assign id_o    = mem_q[0];
  assign ovf_o   = ovf_q;

  // Entry 0 is always the head, so a pop is a shift toward index 0.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (pop) begin
      for (int i = 0; i < int'(TMR_EVT_DEPTH) - 1; i++) mem_d[i] = mem_q[i+1];
      cnt_d = cnt_q - 1'b1;
    end
    if (push_i) begin
      if (cnt_d < DEPTH_C) begin
        mem_d[cnt_d[IW-1:0]] = push_id_i;
        cnt_d = cnt_d + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      mem_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      ovf_q   <= ovf_d | (full & push_i & ~pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40p_tmr_monitor.sv
// ---------------------------------------------------------------------------
// cv32e40p_tmr_monitor : TMR replica comparison, statistics and fault events | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40p_tmr_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PERM_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] err_cnt1_o,
  output logic [CNT_W-1:0] err_cnt2_o,
  output logic [CNT_W-1:0] err_cnt3_o,
  output logic [2:0]       faulty_o,
  output logic             uncorr_o,
  output logic             evt_valid_o,
  output logic [1:0]       evt_id_o,
  input  logic             evt_ready_i,
  output logic             evt_ovf_o
);

  localparam int unsigned CONS_W = $clog2(PERM_THRESH + 1);
  localparam logic [CONS_W-1:0] THRESH_C = CONS_W'(PERM_THRESH);

  logic             e12, e13, e23, uncorr, cmp, push, evt_empty;
  logic [2:0]       flt, hit;
  logic [1:0]       push_id;
  logic [2:0][CNT_W-1:0] err_w;
  logic [2:0]       faulty_q;
  logic             uncorr_q;

  assign e12 = (res1_i == res2_i);
  assign e13 = (res1_i == res3_i);
  assign e23 = (res2_i == res3_i);

  // Equality is transitive, so two equal pairs imply the clean case.
  assign flt[0] = ~e12 & ~e13 &  e23;
  assign flt[1] = ~e12 &  e13 & ~e23;
  assign flt[2] =  e12 & ~e13 & ~e23;
  assign uncorr = ~e12 & ~e13 & ~e23;
  assign cmp    = valid_i & ~clear_i;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_replica
      logic [CNT_W-1:0]  err_q;
      logic [CONS_W-1:0] cons_q, cons_d;

      always_comb begin
        cons_d = cons_q;
        if (cmp && !uncorr) begin
          if (flt[i]) cons_d = (cons_q == THRESH_C) ? cons_q : cons_q + 1'b1;
          else        cons_d = '0;
        end
      end

      assign hit[i]   = (cons_d == THRESH_C);
      assign err_w[i] = err_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_q  <= '0;
          cons_q <= '0;
        end else if (clear_i) begin
          err_q  <= '0;
          cons_q <= '0;
        end else begin
          cons_q <= cons_d;
          if (cmp && flt[i] && !(&err_q)) err_q <= err_q + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faulty_q <= '0;
      uncorr_q <= 1'b0;
    end else if (clear_i) begin
      faulty_q <= '0;
      uncorr_q <= 1'b0;
    end else begin
      faulty_q <= faulty_q | hit;
      if (cmp && uncorr) uncorr_q <= 1'b1;
    end
  end

  assign push    = cmp & (uncorr | (|flt));
  assign push_id = uncorr ? TMR_EVT_UNCORR :
                   flt[0] ? TMR_EVT_R1 :
                   flt[1] ? TMR_EVT_R2 : TMR_EVT_R3;

  cv32e40p_tmr_evt_fifo u_evt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .push_i    (push),
    .push_id_i (push_id),
    .pop_i     (~evt_empty & evt_ready_i),
    .valid_o   (evt_valid_o),
    .empty_o   (evt_empty),
    .id_o      (evt_id_o),
    .ovf_o     (evt_ovf_o)
  );

  assign err_cnt1_o = err_w[0];
  assign err_cnt2_o = err_w[1];
  assign err_cnt3_o = err_w[2];
  assign faulty_o   = faulty_q;
  assign uncorr_o   = uncorr_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_tmr_monitor.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_tmr_monitor : scoreboard bench for the TMR fault monitor | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40p_tmr_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        evt_ready_i = 1'b0;
  logic [31:0] res1_i = '0, res2_i = '0, res3_i = '0;
  logic [7:0]  err_cnt1_o, err_cnt2_o, err_cnt3_o;
  logic [2:0]  faulty_o;
  logic        uncorr_o, evt_valid_o, evt_ovf_o;
  logic [1:0]  evt_id_o;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [1:0]  exp_q[$];

  cv32e40p_tmr_monitor #(.WIDTH(32), .CNT_W(8), .PERM_THRESH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .res1_i      (res1_i),
    .res2_i      (res2_i),
    .res3_i      (res3_i),
    .clear_i     (clear_i),
    .err_cnt1_o  (err_cnt1_o),
    .err_cnt2_o  (err_cnt2_o),
    .err_cnt3_o  (err_cnt3_o),
    .faulty_o    (faulty_o),
    .uncorr_o    (uncorr_o),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i),
    .evt_ovf_o   (evt_ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: every accepted event is compared with the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && evt_valid_o && evt_ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL evt_unexpected: got id %0d, required no event", evt_id_o);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (evt_id_o !== e) begin
          fails++;
          $display("FAIL evt_id: got %0d, required %0d", evt_id_o, e);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    valid_i = v;
    res1_i  = a;
    res2_i  = b;
    res3_i  = c;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic rep_fault(input int r, input int n, input bit exp_evt);
    for (int k = 0; k < n; k++) begin
      if (exp_evt) exp_q.push_back(2'(r));
      case (r)
        1:       cyc(1'b1, 32'd1, 32'd0, 32'd0);
        2:       cyc(1'b1, 32'd5, 32'd6, 32'd5);
        default: cyc(1'b1, 32'd7, 32'd7, 32'd8);
      endcase
    end
  endtask

  task automatic drain(input string nm);
    evt_ready_i = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() != 0 || evt_valid_o); k++) cyc(1'b0, '0, '0, '0);
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_err1", err_cnt1_o, 0);
    chk("rst_err2", err_cnt2_o, 0);
    chk("rst_err3", err_cnt3_o, 0);
    chk("rst_faulty", faulty_o, 0);
    chk("rst_uncorr", uncorr_o, 0);
    chk("rst_evt_valid", evt_valid_o, 0);
    chk("rst_evt_id", evt_id_o, 0);
    chk("rst_ovf", evt_ovf_o, 0);
    rst_n = 1'b1;

    // Clean run
    evt_ready_i = 1'b1;
    repeat (100) cyc(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("clean_err1", err_cnt1_o, 0);
    chk("clean_err2", err_cnt2_o, 0);
    chk("clean_err3", err_cnt3_o, 0);
    chk("clean_faulty", faulty_o, 0);
    chk("clean_evt_valid", evt_valid_o, 0);

    // Single fault with recovery; the extra fault proves the streak was reset
    rep_fault(1, 3, 1'b1);
    chk("single_err1", err_cnt1_o, 3);
    cyc(1'b1, 32'd0, 32'd0, 32'd0);
    drain("single_drain");
    chk("single_faulty", faulty_o, 0);
    rep_fault(1, 1, 1'b1);
    drain("single_drain2");
    chk("single_streak_reset", faulty_o, 0);
    chk("single_err1_b", err_cnt1_o, 4);

    // Permanent fault on replica 2
    rep_fault(2, 3, 1'b1);
    chk("perm_faulty_3", faulty_o, 0);
    rep_fault(2, 1, 1'b1);
    chk("perm_faulty_4", faulty_o, 3'b010);
    repeat (5) cyc(1'b1, 32'd9, 32'd9, 32'd9);
    chk("perm_sticky", faulty_o, 3'b010);
    drain("perm_drain");
    chk("perm_err2", err_cnt2_o, 4);

    // Uncorrectable
    exp_q.push_back(2'd0);
    cyc(1'b1, 32'd1, 32'd2, 32'd3);
    chk("uncorr_flag", uncorr_o, 1);
    chk("uncorr_err1", err_cnt1_o, 4);
    chk("uncorr_err2", err_cnt2_o, 4);
    chk("uncorr_err3", err_cnt3_o, 0);
    drain("uncorr_drain");

    // Overflow: third event dropped, then push+pop on a full queue
    evt_ready_i = 1'b0;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    rep_fault(3, 3, 1'b0);
    chk("ovf_flag", evt_ovf_o, 1);
    chk("ovf_err3", err_cnt3_o, 3);
    chk("ovf_evt_valid", evt_valid_o, 1);
    chk("ovf_evt_id", evt_id_o, 3);
    evt_ready_i = 1'b1;
    rep_fault(3, 1, 1'b1);
    drain("ovf_no_drop_drain");
    chk("ovf_err3_b", err_cnt3_o, 4);
    chk("ovf_faulty", faulty_o, 3'b110);

    // Saturation of the replica-1 total
    rep_fault(1, 251, 1'b1);
    chk("sat_err1_255", err_cnt1_o, 255);
    rep_fault(1, 3, 1'b1);
    chk("sat_err1_hold", err_cnt1_o, 255);
    chk("sat_faulty", faulty_o, 3'b111);

    // Clear beats a simultaneous faulting comparison
    clear_i = 1'b1;
    cyc(1'b1, 32'd1, 32'd0, 32'd0);
    clear_i = 1'b0;
    chk("clr_err1", err_cnt1_o, 0);
    chk("clr_err2", err_cnt2_o, 0);
    chk("clr_err3", err_cnt3_o, 0);
    chk("clr_faulty", faulty_o, 0);
    chk("clr_uncorr", uncorr_o, 0);
    chk("clr_evt_valid", evt_valid_o, 0);
    chk("clr_ovf", evt_ovf_o, 0);
    chk("clr_pending", exp_q.size(), 0);

    // Asynchronous reset discards a queued event at once
    evt_ready_i = 1'b0;
    rep_fault(1, 1, 1'b0);
    chk("arst_pre_valid", evt_valid_o, 1);
    chk("arst_pre_err1", err_cnt1_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_evt_valid", evt_valid_o, 0);
    chk("arst_err1", err_cnt1_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
